// File: rtl/mem_interface.sv
// mem_interface: 8 KiB little-endian RAM plus memory-mapped LED/PWM register
// and optional millis/micros timers behind a single store port and a single
// load port.
//
// Build option: define MEM_TIMERS_EN to include the millis (0xFFFFFFF8) and
// micros (0xFFFFFFF4) counters. Without it those addresses read as zero and
// no timer logic exists.
//
// Load data appears on memory_rd one cycle after memory_ra/memory_func3 are
// sampled. A store and a load to the same word in one cycle return the
// pre-store contents.
module mem_interface #(
  parameter string INIT_FILE   = "",
  parameter int    CLK_FREQ_HZ = 12000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_wen,
  input  logic [2:0]  memory_func3,
  input  logic [31:0] memory_wa,
  input  logic [31:0] memory_wd,
  input  logic [31:0] memory_ra,
  output logic [31:0] memory_rd,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int          RAM_WORDS = 2048;
  localparam logic [31:0] LED_ADDR  = 32'hFFFF_FFFC;
  localparam logic [31:0] MS_ADDR   = 32'hFFFF_FFF8;
  localparam logic [31:0] US_ADDR   = 32'hFFFF_FFF4;

  // access-size field encodings (low two bits give the size, bit 2 = unsigned)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The prescalers need at least 1 kHz of clock to produce a millisecond tick.
  if (CLK_FREQ_HZ < 1000) begin : g_clk_check
    $error("mem_interface: CLK_FREQ_HZ must be at least 1000");
  end

  // An access is honoured only for a legal size code at a naturally aligned
  // address; everything else is ignored on stores and reads as zero.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~lo[0];
      F3_W:        ok = (lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ---------------------------------------------------------------------
  // Store path: byte enables and lane-replicated data
  // ---------------------------------------------------------------------
  logic        st_ok;
  logic        st_ram;
  logic        st_led;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  assign st_ok  = memory_wen & access_ok(memory_func3, memory_wa[1:0]);
  assign st_ram = (memory_wa[31:13] == 19'd0);
  assign st_led = (memory_wa[31:2] == LED_ADDR[31:2]);

  // Right-aligned store data is replicated into every lane it may land in;
  // the byte enable then picks the lanes that are actually written.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_st_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign st_be[gi] = (memory_func3[1:0] == 2'b00) ? (memory_wa[1:0] == LANE) :
                       (memory_func3[1:0] == 2'b01) ? (memory_wa[1] == LANE[1]) :
                                                      1'b1;
    assign st_data[8*gi +: 8] = (memory_func3[1:0] == 2'b00) ? memory_wd[7:0] :
                                (memory_func3[1:0] == 2'b01) ? memory_wd[8*(gi%2) +: 8] :
                                                               memory_wd[8*gi +: 8];
  end

  // ---------------------------------------------------------------------
  // RAM: 2048 x 32, byte-enabled write, registered read
  // ---------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_q;
  logic [10:0] wr_idx;
  logic [10:0] rd_idx;

  assign wr_idx = memory_wa[12:2];
  assign rd_idx = memory_ra[12:2];

  // Byte-enabled RAM write; reset only blocks stores, it never clears contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // contents deliberately retained through reset
    end else if (st_ok && st_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) ram[wr_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Registered RAM read; sees the word as it was before any same-edge store.
  always_ff @(posedge clk) begin
    ram_q <= ram[rd_idx];
  end

  // ---------------------------------------------------------------------
  // LED duty register
  // ---------------------------------------------------------------------
  logic [31:0] led_reg;

  // Byte-addressable duty register: byte0 led, byte1 red, byte2 green, byte3 blue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= '0;
    end else if (st_ok && st_led) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) led_reg[8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------
  logic [7:0] pwm_cnt_reg;

  // Free-running 8-bit PWM phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_reg <= '0;
    else        pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
  end

  // Each output is high while the phase is below its duty byte, so a duty of
  // 0 never lights and 255 lights for 255 of every 256 cycles.
  assign led   = (pwm_cnt_reg < led_reg[7:0]);
  assign red   = (pwm_cnt_reg < led_reg[15:8]);
  assign green = (pwm_cnt_reg < led_reg[23:16]);
  assign blue  = (pwm_cnt_reg < led_reg[31:24]);

  // ---------------------------------------------------------------------
  // Timers
  // ---------------------------------------------------------------------
  logic [31:0] millis_val;
  logic [31:0] micros_val;

`ifdef MEM_TIMERS_EN
  localparam int US_DIV = (CLK_FREQ_HZ >= 1000000) ? CLK_FREQ_HZ / 1000000 : 1;
  localparam int MS_DIV = (CLK_FREQ_HZ >= 1000)    ? CLK_FREQ_HZ / 1000    : 1;

  logic [31:0] us_pre_reg;
  logic [31:0] ms_pre_reg;
  logic [31:0] micros_reg;
  logic [31:0] millis_reg;

  // Microsecond prescaler and counter; the counter wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_pre_reg <= '0;
      micros_reg <= '0;
    end else if (us_pre_reg == 32'(US_DIV - 1)) begin
      us_pre_reg <= '0;
      micros_reg <= micros_reg + 32'd1;
    end else begin
      us_pre_reg <= us_pre_reg + 32'd1;
    end
  end

  // Millisecond prescaler and counter, independent of the microsecond chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_pre_reg <= '0;
      millis_reg <= '0;
    end else if (ms_pre_reg == 32'(MS_DIV - 1)) begin
      ms_pre_reg <= '0;
      millis_reg <= millis_reg + 32'd1;
    end else begin
      ms_pre_reg <= ms_pre_reg + 32'd1;
    end
  end

  assign millis_val = millis_reg;
  assign micros_val = micros_reg;
`else
  assign millis_val = '0;
  assign micros_val = '0;
`endif

  // ---------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------
  logic [31:0] io_word;
  logic        ld_ok_reg;
  logic        ld_ram_reg;
  logic [31:0] ld_io_reg;
  logic [1:0]  ld_lo_reg;
  logic [2:0]  ld_func3_reg;

  // Word from the register space at the load address; zero when unmapped.
  always_comb begin
    io_word = '0;
    if (memory_ra[31:2] == LED_ADDR[31:2])     io_word = led_reg;
    else if (memory_ra[31:2] == MS_ADDR[31:2]) io_word = millis_val;
    else if (memory_ra[31:2] == US_ADDR[31:2]) io_word = micros_val;
  end

  // Capture the request alongside the RAM read so both line up next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ok_reg    <= 1'b0;
      ld_ram_reg   <= 1'b0;
      ld_io_reg    <= '0;
      ld_lo_reg    <= '0;
      ld_func3_reg <= '0;
    end else begin
      ld_ok_reg    <= access_ok(memory_func3, memory_ra[1:0]);
      ld_ram_reg   <= (memory_ra[31:13] == 19'd0);
      ld_io_reg    <= io_word;
      ld_lo_reg    <= memory_ra[1:0];
      ld_func3_reg <= memory_func3;
    end
  end

  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane selection and sign/zero extension of the registered load.
  always_comb begin
    ld_word = ld_ram_reg ? ram_q : ld_io_reg;
    case (ld_lo_reg)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half   = ld_lo_reg[1] ? ld_word[31:16] : ld_word[15:0];
    memory_rd = '0;
    if (ld_ok_reg) begin
      case (ld_func3_reg)
        F3_B:    memory_rd = {{24{ld_byte[7]}}, ld_byte};
        F3_BU:   memory_rd = {24'd0, ld_byte};
        F3_H:    memory_rd = {{16{ld_half[15]}}, ld_half};
        F3_HU:   memory_rd = {16'd0, ld_half};
        F3_W:    memory_rd = ld_word;
        default: memory_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed stimulus with literal expectations, plus a
// byte-level reference model of RAM, LED register and PWM compared every cycle.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        memory_wen = 1'b0;
  logic [2:0]  memory_func3 = 3'b010;
  logic [31:0] memory_wa = '0;
  logic [31:0] memory_wd = '0;
  logic [31:0] memory_ra = '0;
  logic [31:0] memory_rd;
  logic        led, red, green, blue;

  always #5 clk = ~clk;

  mem_interface dut (
    .clk(clk), .rst_n(rst_n), .memory_wen(memory_wen), .memory_func3(memory_func3),
    .memory_wa(memory_wa), .memory_wd(memory_wd), .memory_ra(memory_ra),
    .memory_rd(memory_rd), .led(led), .red(red), .green(green), .blue(blue)
  );

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [8192];
  bit          knw   [8192];
  logic [7:0]  led_m [4];
  logic [7:0]  pwm_m = '0;
  logic [31:0] exp_rd = '0;
  bit          exp_chk = 1'b0;
  bit          mdl_live = 1'b0;

  function automatic bit acc_ok(input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!(f3 inside {B, H, W, BU, HU})) return 1'b0;
    n = 1 << f3[1:0];
    return (a % n) == 0;
  endfunction

  function automatic void mload(input logic [2:0] f3, input logic [31:0] a,
                                output logic [31:0] v, output bit ok);
    int n;
    logic [31:0] raw, b;
    raw = '0; v = '0; ok = 1'b1;
    if (!acc_ok(f3, a)) return;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) begin
      b = a + 32'(i);
      if (b < 32'h2000) begin
        if (!knw[b[12:0]]) ok = 1'b0;
        raw = raw | (32'(mem_m[b[12:0]]) << (8 * i));
      end else if (b >= 32'hFFFF_FFFC) begin
        raw = raw | (32'(led_m[b[1:0]]) << (8 * i));
      end
`ifdef MEM_TIMERS_EN
      else if (b >= 32'hFFFF_FFF4) ok = 1'b0;
`endif
    end
    if (n == 1)      v = f3[2] ? raw : {{24{raw[7]}}, raw[7:0]};
    else if (n == 2) v = f3[2] ? raw : {{16{raw[15]}}, raw[15:0]};
    else             v = raw;
  endfunction

  function automatic void mstore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [31:0] b;
    if (!acc_ok(f3, a)) return;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) begin
      b = a + 32'(i);
      if (b < 32'h2000) begin
        mem_m[b[12:0]] = d[8*i +: 8];
        knw[b[12:0]] = 1'b1;
      end else if (b >= 32'hFFFF_FFFC) begin
        led_m[b[1:0]] = d[8*i +: 8];
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rd = '0; exp_chk = 1'b1; pwm_m = '0; mdl_live = 1'b1;
      for (int i = 0; i < 4; i++) led_m[i] = '0;
    end else begin
      mload(memory_func3, memory_ra, exp_rd, exp_chk);
      if (memory_wen) mstore(memory_func3, memory_wa, memory_wd);
      pwm_m = pwm_m + 8'd1;
    end
  end

  logic [3:0] pwm_exp;
  always @(negedge clk) begin
    if (mdl_live) begin
      if (exp_chk) begin
        checks++;
        if (memory_rd !== exp_rd) begin
          failures++;
          $display("FAIL model_rd t=%0t actual=%h required=%h", $time, memory_rd, exp_rd);
        end
      end
      pwm_exp = {pwm_m < led_m[0], pwm_m < led_m[1], pwm_m < led_m[2], pwm_m < led_m[3]};
      checks++;
      if ({led, red, green, blue} !== pwm_exp) begin
        failures++;
        $display("FAIL model_pwm t=%0t actual=%b required=%b", $time, {led, red, green, blue}, pwm_exp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end else begin
      $display("ok   %s value=%h", nm, act);
    end
  endtask

  task automatic step(input logic wen, input logic [2:0] f3, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] ra);
    memory_wen = wen; memory_func3 = f3; memory_wa = wa; memory_wd = wd; memory_ra = ra;
    @(posedge clk); #1;
    memory_wen = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] ra, input string nm, input logic [31:0] req);
    step(1'b0, f3, 32'h0, 32'h0, ra);
    chk(nm, memory_rd, req);
  endtask

  task automatic count_pwm(output int cl, output int cr, output int cg, output int cb);
    cl = 0; cr = 0; cg = 0; cb = 0;
    repeat (256) begin
      @(posedge clk); #1;
      cl += int'(led); cr += int'(red); cg += int'(green); cb += int'(blue);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int cl, cr, cg, cb;

  initial begin
    #3;
    do_reset();
    chk("reset_rd", memory_rd, 32'h0);
    chk("reset_pwm", {28'd0, led, red, green, blue}, 32'h0);

    // first store honoured on the first edge after release
    rst_n = 1'b1;
    step(1'b1, W, 32'h104, 32'hCAFE_F00D, 32'h0);
    ld(W, 32'h104, "first_store_after_reset", 32'hCAFE_F00D);

    // sized loads of one word
    step(1'b1, W, 32'h100, 32'h80FF_7F01, 32'h0);
    ld(B,  32'h103, "lb_103", 32'hFFFF_FF80);
    ld(BU, 32'h103, "lbu_103", 32'h0000_0080);
    ld(H,  32'h102, "lh_102", 32'hFFFF_80FF);
    ld(HU, 32'h100, "lhu_100", 32'h0000_7F01);
    ld(W,  32'h100, "lw_100", 32'h80FF_7F01);
    ld(B,  32'h101, "lb_101", 32'h0000_007F);
    ld(H,  32'h101, "lh_misaligned", 32'h0);
    ld(W,  32'h102, "lw_misaligned", 32'h0);
    ld(3'b011, 32'h100, "illegal_f3_load", 32'h0);

    // byte / halfword stores merge into the word
    step(1'b1, W, 32'h200, 32'h1122_3344, 32'h0);
    step(1'b1, B, 32'h201, 32'h0000_00AB, 32'h0);
    ld(W, 32'h200, "sb_merge", 32'h1122_AB44);
    step(1'b1, H, 32'h203, 32'h0000_5555, 32'h203);
    chk("lh_203_misaligned", memory_rd, 32'h0);
    ld(W, 32'h200, "sh_misaligned_ignored", 32'h1122_AB44);
    step(1'b1, H, 32'h202, 32'h0000_BEEF, 32'h0);
    ld(W, 32'h200, "sh_merge", 32'hBEEF_AB44);
    step(1'b1, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h0);
    ld(W, 32'h200, "illegal_f3_store", 32'hBEEF_AB44);

    // read-before-write on the same word
    step(1'b1, W, 32'h300, 32'h1234_5678, 32'h0);
    step(1'b1, W, 32'h300, 32'hDEAD_BEEF, 32'h300);
    chk("rbw_old", memory_rd, 32'h1234_5678);
    ld(W, 32'h300, "rbw_new", 32'hDEAD_BEEF);

    // unmapped space and the timer window in the default build
    step(1'b1, W, 32'h2000, 32'h5A5A_5A5A, 32'h0);
    ld(W, 32'h2000, "unmapped_2000", 32'h0);
    ld(W, 32'h8000_0000, "unmapped_high", 32'h0);
    step(1'b1, W, 32'hFFFF_FFF8, 32'h7777_7777, 32'h0);
`ifndef MEM_TIMERS_EN
    ld(W, 32'hFFFF_FFF8, "millis_disabled", 32'h0);
    ld(W, 32'hFFFF_FFF4, "micros_disabled", 32'h0);
`endif

    // LED register and PWM duty
    step(1'b1, W, 32'hFFFF_FFFC, 32'h0000_80FF, 32'hFFFF_FFFC);
    chk("led_rbw_old", memory_rd, 32'h0);
    ld(W, 32'hFFFF_FFFC, "led_readback", 32'h0000_80FF);
    ld(BU, 32'hFFFF_FFFD, "led_red_byte", 32'h0000_0080);
    count_pwm(cl, cr, cg, cb);
    chk("pwm_led_255", 32'(cl), 32'd255);
    chk("pwm_red_128", 32'(cr), 32'd128);
    chk("pwm_green_0", 32'(cg), 32'd0);
    chk("pwm_blue_0", 32'(cb), 32'd0);
    step(1'b1, B, 32'hFFFF_FFFE, 32'h0000_0040, 32'h0);
    count_pwm(cl, cr, cg, cb);
    chk("pwm_green_64", 32'(cg), 32'd64);

    // asynchronous reset mid-PWM
    step(1'b1, W, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0);
    step(1'b0, W, 32'h0, 32'h0, 32'h100);
    step(1'b0, W, 32'h0, 32'h0, 32'h100);
    chk("pre_reset_rd", memory_rd, 32'h80FF_7F01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rd", memory_rd, 32'h0);
    chk("async_reset_pwm", {28'd0, led, red, green, blue}, 32'h0);
    memory_wen = 1'b1; memory_func3 = W; memory_wa = 32'h100; memory_wd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_pwm", {28'd0, led, red, green, blue}, 32'h0);
    memory_wen = 1'b0;
    rst_n = 1'b1;
    ld(W, 32'h100, "ram_retained", 32'h80FF_7F01);
    ld(W, 32'hFFFF_FFFC, "led_cleared", 32'h0);

`ifdef MEM_TIMERS_EN
    // micros wrap: forced to all-ones right after release, ticks on edge 12
    do_reset();
    rst_n = 1'b1;
    dut.micros_reg = 32'hFFFF_FFFF;
    repeat (11) step(1'b0, W, 32'h0, 32'h0, 32'h0);
    ld(W, 32'hFFFF_FFF4, "micros_before_wrap", 32'hFFFF_FFFF);
    ld(W, 32'hFFFF_FFF4, "micros_wrapped", 32'h0);
    // 12000 cycles after reset: one millisecond, one thousand microseconds
    do_reset();
    rst_n = 1'b1;
    repeat (12000) step(1'b0, W, 32'h0, 32'h0, 32'h0);
    ld(W, 32'hFFFF_FFF8, "millis_12000", 32'd1);
    ld(W, 32'hFFFF_FFF4, "micros_12001", 32'd1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
